sumador_multiciclo: RTL and testbench

SUMADOR_MULTICICLO -- requirements
Module: sumador_multiciclo

---
 rtl/sumador_multiciclo.sv | 122 ++++++++++++
 tb/tb_sumador_multiciclo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_multiciclo.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle with a ripple carry,
// valid/ready handshake on both sides and registered result flags.
module sumador_multiciclo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = ($clog2(NCHUNK + 1) > 1) ? $clog2(NCHUNK + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_next;
  logic             last_chunk;
  logic             accept;

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // Chunk select and write-back use constant slices so no index can go out of range.
  always_comb begin
    chunk_a  = '0;
    chunk_b  = '0;
    sum_next = sum_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = bx_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        sum_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)   state_d = StCalc;
      StCalc:  if (last_chunk) state_d = StDone;
      StDone:  if (out_ready)  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      bx_q      <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      S         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1.
      a_q     <= A;
      bx_q    <= op ? ~B : B;
      carry_q <= op ? 1'b1 : Cin;
      k_q     <= '0;
    end else if (state_q == StCalc) begin
      sum_q   <= sum_next;
      carry_q <= chunk_sum[CHUNK];
      k_q     <= k_q + KW'(1);
      if (last_chunk) begin
        S         <= sum_next;
        carry_out <= chunk_sum[CHUNK];
        overflow  <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
        zero      <= (sum_next == '0);
        negative  <= sum_next[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sumador_multiciclo.sv
// Scoreboard bench for sumador_multiciclo: directed cases on a CHUNK=2 instance and
// random back-to-back traffic on CHUNK=2 and CHUNK=WIDTH instances.
module tb_sumador_multiciclo;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
    logic       n;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_ready, cin = 1'b0, op = 1'b0;
  logic [7:0] a = '0, b = '0, s;
  logic       out_valid, out_ready = 1'b0, co, ovf, zer, neg;

  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, op8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       out_valid8, out_ready8 = 1'b0, co8, ovf8, zer8, neg8;

  res_t q2[$];
  res_t q8[$];
  res_t last_e;
  logic [7:0] last_s = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sumador_multiciclo #(.WIDTH(8), .CHUNK(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .Cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .S(s),
    .carry_out(co), .overflow(ovf), .zero(zer), .negative(neg)
  );

  sumador_multiciclo #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
    .Cin(cin8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8), .S(s8),
    .carry_out(co8), .overflow(ovf8), .zero(zer8), .negative(neg8)
  );

  function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mc, input logic mo);
    logic [7:0] bx;
    logic [8:0] t;
    res_t r;
    bx   = mo ? ~mb : mb;
    t    = {1'b0, ma} + {1'b0, bx} + {8'b0, (mo ? 1'b1 : mc)};
    r.s  = t[7:0];
    r.co = t[8];
    r.ov = (ma[7] == bx[7]) && (t[7] != ma[7]);
    r.z  = (t[7:0] == 8'h00);
    r.n  = t[7];
    return r;
  endfunction

  // Accepts one op on dut2 and leaves it waiting in DONE with the result checked.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input logic top, input res_t e);
    int nc;
    res_t x;
    nc = 0;
    while (!in_ready && nc < 20) begin
      @(posedge clk); #1; nc++;
    end
    a = ta; b = tbv; cin = tc; op = top; in_valid = 1'b1;
    q2.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
    nc = 0;
    while (!out_valid && nc < 20) begin
      checks++;
      if (s !== last_s) begin
        errors++; $display("FAIL hold_s_calc: S=%h required %h", s, last_s);
      end
      @(posedge clk); #1; nc++;
    end
    checks++;
    if (nc !== 4) begin
      errors++; $display("FAIL latency: %0d edges, required 4", nc);
    end
    x = q2.pop_front();
    checks++;
    if ({s, co, ovf, zer, neg} !== x) begin
      errors++;
      $display("FAIL result %h op=%0d %h: S/co/ov/z/n=%h/%b%b%b%b required %h/%b%b%b%b",
               ta, top, tbv, s, co, ovf, zer, neg, x.s, x.co, x.ov, x.z, x.n);
    end
    last_e = x;
    last_s = x.s;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL release: out_valid/in_ready=%b%b required 01", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, in_ready, s, co, ovf, zer, neg} !== {2'b01, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL reset_state: ov/ir=%b%b S=%h flags=%b%b%b%b required 01 00 0000",
                         out_valid, in_ready, s, co, ovf, zer, neg);
    end
    checks++;
    if ({out_valid8, in_ready8, s8} !== {2'b01, 8'h00}) begin
      errors++; $display("FAIL reset_state8: ov/ir=%b%b S=%h required 01 00",
                         out_valid8, in_ready8, s8);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, '{s: 8'h80, co: 1'b0, ov: 1'b1, z: 1'b0, n: 1'b1});
    finish_op();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, '{s: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1, n: 1'b0});
    finish_op();
    run_op(8'h00, 8'h00, 1'b1, 1'b0, '{s: 8'h01, co: 1'b0, ov: 1'b0, z: 1'b0, n: 1'b0});
    finish_op();
  endtask

  task automatic test_sub();
    run_op(8'h05, 8'h07, 1'b0, 1'b1, '{s: 8'hFE, co: 1'b0, ov: 1'b0, z: 1'b0, n: 1'b1});
    finish_op();
    // Cin must be ignored in subtract mode.
    run_op(8'h80, 8'h01, 1'b1, 1'b1, '{s: 8'h7F, co: 1'b1, ov: 1'b1, z: 1'b0, n: 1'b0});
    finish_op();
  endtask

  task automatic test_backpressure();
    run_op(8'h3C, 8'h4B, 1'b1, 1'b0, '{s: 8'h88, co: 1'b0, ov: 1'b1, z: 1'b0, n: 1'b1});
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, s, co, ovf, zer, neg} !== {2'b10, last_e}) begin
        errors++; $display("FAIL backpressure cycle %0d: ov/ir=%b%b S=%h required 10 %h",
                           i, out_valid, in_ready, s, last_e.s);
      end
    end
    in_valid = 1'b0;
    finish_op();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, s} !== {2'b01, last_e.s}) begin
      errors++; $display("FAIL no_second_accept: ov/ir=%b%b S=%h required 01 %h",
                         out_valid, in_ready, s, last_e.s);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    a = 8'h44; b = 8'h55; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, s, co, ovf, zer, neg} !== {2'b01, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL reset_abort: ov/ir=%b%b S=%h flags=%b%b%b%b required 01 00 0000",
                         out_valid, in_ready, s, co, ovf, zer, neg);
    end
    @(negedge clk); rst_n = 1'b1;
    last_s = 8'h00;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_no_pulse: out_valid seen %0d cycles, required 0", seen);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, '{s: 8'h30, co: 1'b0, ov: 1'b0, z: 1'b0, n: 1'b0});
    finish_op();
  endtask

  task automatic test_back_to_back();
    int d2, c2, d8, c8;
    res_t x;
    d2 = 0; c2 = 0; d8 = 0; c8 = 0;
    fork
      begin
        while (d2 < 10000 && c2 < 80000) begin
          if (in_valid && in_ready) q2.push_back(model(a, b, cin, op));
          if (out_valid && out_ready) begin
            checks++;
            if (q2.size() == 0) begin
              errors++; $display("FAIL rand2_unexpected: output with empty scoreboard");
            end else begin
              x = q2.pop_front();
              if ({s, co, ovf, zer, neg} !== x) begin
                errors++; $display("FAIL rand2 #%0d: got %h/%b%b%b%b required %h/%b%b%b%b", d2,
                                   s, co, ovf, zer, neg, x.s, x.co, x.ov, x.z, x.n);
              end
            end
            d2++;
          end
          @(posedge clk); #1; c2++;
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
          in_valid = ($urandom_range(3) != 0);
          out_ready = ($urandom_range(3) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b0;
      end
      begin
        while (d8 < 10000 && c8 < 80000) begin
          if (in_valid8 && in_ready8) q8.push_back(model(a8, b8, cin8, op8));
          if (out_valid8 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
              errors++; $display("FAIL rand8_unexpected: output with empty scoreboard");
            end else begin
              x = q8.pop_front();
              if ({s8, co8, ovf8, zer8, neg8} !== x) begin
                errors++; $display("FAIL rand8 #%0d: got %h/%b%b%b%b required %h/%b%b%b%b", d8,
                                   s8, co8, ovf8, zer8, neg8, x.s, x.co, x.ov, x.z, x.n);
              end
            end
            d8++;
          end
          // One CALC cycle: accept, then DONE on the very next edge.
          if (in_valid8 && in_ready8) begin
            @(posedge clk); #1; c8++;
            in_valid8 = 1'b0;
            checks++;
            if (in_ready8 !== 1'b0) begin
              errors++; $display("FAIL rand8_accept: in_ready=%b required 0", in_ready8);
            end
          end
          @(posedge clk); #1; c8++;
          a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); op8 = 1'($urandom);
          in_valid8 = ($urandom_range(3) != 0);
          out_ready8 = ($urandom_range(3) != 0);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
      end
    join
    checks++;
    if (d2 !== 10000) begin
      errors++; $display("FAIL rand2_timeout: %0d ops completed, required 10000", d2);
    end
    checks++;
    if (d8 !== 10000) begin
      errors++; $display("FAIL rand8_timeout: %0d ops completed, required 10000", d8);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
